// File: rtl/eth_helper_pkg.sv
// Shared definitions for the Ethernet helper link B-channel path.
// Contents:
//   B_TAG              channel tag that marks a stream word as a write response
//   BRESP_LSB, BID_LSB field offsets inside a stream word
//   TAG_WIDTH          width of the channel tag held in the top bits of a word
//   resp_e             AXI response codes
//   buser_lsb()        offset of BUSER, which follows BID
//   tag_lsb()          offset of the tag, which sits in the top bits of a word
package eth_helper_pkg;

    localparam logic [3:0] B_TAG     = 4'h4;
    localparam int         BRESP_LSB = 0;
    localparam int         BID_LSB   = 2;
    localparam int         TAG_WIDTH = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    function automatic int buser_lsb(input int id_width);
        return BID_LSB + id_width;
    endfunction

    function automatic int tag_lsb(input int data_width);
        return data_width - TAG_WIDTH;
    endfunction

endpackage

// File: rtl/stream_to_axi_b_if.sv
// Bundles the inbound stream and the outbound AXI B channel of stream_to_axi_b.
// Signals:
//   s_valid, s_data, s_ready                 inbound stream handshake and word
//   AXIM_bid, AXIM_bresp, AXIM_buser         regenerated write response fields
//   AXIM_bvalid, AXIM_bready                 AXI B handshake
// Modports:
//   master  the forwarder itself (sinks the stream, masters the B channel)
//   slave   the surrounding logic (sources the stream, accepts responses)
interface stream_to_axi_b_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64
) ();

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    logic [ID_WIDTH-1:0]   AXIM_bid;
    logic [1:0]            AXIM_bresp;
    logic [USER_WIDTH-1:0] AXIM_buser;
    logic                  AXIM_bvalid;
    logic                  AXIM_bready;

    modport master (
        input  s_valid, s_data, AXIM_bready,
        output s_ready, AXIM_bid, AXIM_bresp, AXIM_buser, AXIM_bvalid
    );

    modport slave (
        output s_valid, s_data, AXIM_bready,
        input  s_ready, AXIM_bid, AXIM_bresp, AXIM_buser, AXIM_bvalid
    );

endinterface

// File: rtl/stream_to_axi_b_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, push_data  write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   head         oldest entry, forced to zero while empty
//   full, empty  occupancy flags, derived from registered pointers only
//   fill         number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits are equal.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill  = wr_ptr - rd_ptr;

    // Storage is not reset, so the head is masked to keep outputs at zero
    // whenever nothing is buffered.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/stream_to_axi_b.sv
// stream_to_axi_b: regenerates AXI write responses from tagged stream words.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          stream sink plus AXI B master (stream_to_axi_b_if.master)
//   fill         number of buffered responses
//   drop         one-cycle pulse after a word with a foreign tag was consumed
//   drop_count   saturating count of consumed foreign-tag words
module stream_to_axi_b
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    stream_to_axi_b_if.master             bus,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          drop,
    output logic [15:0]                   drop_count
);

    localparam int ENTRY_W   = ID_WIDTH + 2 + USER_WIDTH;
    localparam int BUSER_LSB = buser_lsb(ID_WIDTH);
    localparam int TAG_LSB   = tag_lsb(DATA_WIDTH);

    if (ID_WIDTH + USER_WIDTH + 6 > DATA_WIDTH) begin : g_bad_layout
        $error("stream_to_axi_b: DATA_WIDTH too small for BID, BRESP, BUSER and tag");
    end

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_to_axi_b: FIFO_DEPTH must be a power of two between 2 and 16");
    end

    logic               running;
    logic [3:0]         tag;
    logic               accept;
    logic               push;
    logic               bad_word;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               unused_data;

    // Holds s_ready low while reset is applied and releases it on the first
    // clock after reset drops, without any combinational path from reset.
    always_ff @(posedge clk) begin
        if (reset)
            running <= 1'b0;
        else
            running <= 1'b1;
    end

    assign tag          = bus.s_data[TAG_LSB +: TAG_WIDTH];
    assign bus.s_ready  = running && !full;
    assign accept       = bus.s_valid && bus.s_ready;
    assign push         = accept && (tag == B_TAG);
    assign bad_word     = accept && (tag != B_TAG);
    assign pop          = bus.AXIM_bvalid && bus.AXIM_bready;
    assign unused_data  = ^bus.s_data;

    assign push_entry = {bus.s_data[BID_LSB +: ID_WIDTH],
                         bus.s_data[BRESP_LSB +: 2],
                         bus.s_data[BUSER_LSB +: USER_WIDTH]};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );

    assign {bus.AXIM_bid, bus.AXIM_bresp, bus.AXIM_buser} = head;
    assign bus.AXIM_bvalid = !empty;

    // Foreign-tag words are swallowed; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop       <= 1'b0;
            drop_count <= '0;
        end else begin
            drop <= bad_word;
            if (bad_word && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_to_axi_b.sv
// Self-checking bench for stream_to_axi_b with the default 128/32/64/4 sizing.
// A negedge monitor keeps a scoreboard of accepted responses and checks every
// B handshake and the hold-while-stalled rule; the main thread runs directed
// sequences, a table of tagged words and a randomised backpressure phase.
module tb_stream_to_axi_b;

    typedef struct packed {
        logic [31:0] bid;
        logic [1:0]  bresp;
        logic [63:0] buser;
    } resp_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] bid;
        logic [1:0]  bresp;
        logic [63:0] buser;
        logic        exp_drop;
        logic [15:0] exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  fill;
    logic        drop;
    logic [15:0] drop_count;

    int    checks = 0;
    int    failures = 0;
    int    pop_count = 0;
    resp_t exp_q[$];
    resp_t cur_resp;
    logic  cur_good;
    logic  hold_valid;
    resp_t held;

    stream_to_axi_b_if #(.DATA_WIDTH(128), .ID_WIDTH(32), .USER_WIDTH(64)) bus ();

    stream_to_axi_b #(
        .DATA_WIDTH (128),
        .ID_WIDTH   (32),
        .USER_WIDTH (64),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fill       (fill),
        .drop       (drop),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] tag, input logic [31:0] bid,
                                 input logic [1:0] bresp, input logic [63:0] buser, input logic bready);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[1:0]     = bresp;
        w[33:2]    = bid;
        w[97:34]   = buser;
        w[127:124] = tag;
        bus.s_valid     = valid;
        bus.s_data      = w;
        bus.AXIM_bready = bready;
        cur_good = (tag == 4'h4);
        cur_resp = {bid, bresp, buser};
    endtask

    // Scoreboard and AXI hold-rule monitor, sampled mid-cycle.
    always @(negedge clk) begin
        resp_t got;
        resp_t exp;
        got = {bus.AXIM_bid, bus.AXIM_bresp, bus.AXIM_buser};
        if (reset) begin
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                checkOutput("hold_bvalid", 128'(bus.AXIM_bvalid), 128'(1));
                checkOutput("hold_fields", 128'(got), 128'(held));
            end
            if (bus.AXIM_bvalid && bus.AXIM_bready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL pop_unexpected actual=%0h expected=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput("pop_data", 128'(got), 128'(exp));
                end
            end
            if (bus.s_valid && bus.s_ready && cur_good)
                exp_q.push_back(cur_resp);
            hold_valid = bus.AXIM_bvalid && !bus.AXIM_bready;
            held = got;
        end
    end

    initial begin
        #5_000_000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[8];
        int   base;
        int   cyc;
        int   sent;
        int   bad_count;
        logic will_acc;

        vecs[0] = '{4'h4, 32'h21, 2'd0, 64'h1,  1'b0, 16'd0};
        vecs[1] = '{4'h3, 32'h22, 2'd1, 64'h2,  1'b1, 16'd1};
        vecs[2] = '{4'h4, 32'h23, 2'd3, 64'h3,  1'b0, 16'd1};
        vecs[3] = '{4'h3, 32'h24, 2'd2, 64'h4,  1'b1, 16'd2};
        vecs[4] = '{4'h3, 32'h25, 2'd0, 64'h5,  1'b1, 16'd3};
        vecs[5] = '{4'h0, 32'h26, 2'd1, 64'h6,  1'b1, 16'd4};
        vecs[6] = '{4'h4, 32'h27, 2'd1, 64'h7,  1'b0, 16'd4};
        vecs[7] = '{4'hF, 32'h28, 2'd2, 64'h8,  1'b1, 16'd5};

        reset = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 2'd0, 64'h0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_s_ready", 128'(bus.s_ready), 128'(0));
        checkOutput("rst_bvalid", 128'(bus.AXIM_bvalid), 128'(0));
        checkOutput("rst_fields", 128'({bus.AXIM_bid, bus.AXIM_bresp, bus.AXIM_buser}), 128'(0));
        checkOutput("rst_fill", 128'(fill), 128'(0));
        checkOutput("rst_drop", 128'({drop, drop_count}), 128'(0));
        reset = 1'b0;
        tick();
        checkOutput("ready_after_rst", 128'(bus.s_ready), 128'(1));

        // Single response held under backpressure.
        $display("[TB] single response");
        applyStimulus(1'b1, 4'h4, 32'h12, 2'd2, 64'hAB, 1'b0);
        tick();
        bus.s_valid = 1'b0;
        checkOutput("single_bvalid", 128'(bus.AXIM_bvalid), 128'(1));
        checkOutput("single_fields", 128'({bus.AXIM_bid, bus.AXIM_bresp, bus.AXIM_buser}),
                    128'({32'h12, 2'd2, 64'hAB}));
        checkOutput("single_fill", 128'(fill), 128'(1));
        repeat (10) tick();
        checkOutput("single_stable", 128'({bus.AXIM_bvalid, bus.AXIM_bid, bus.AXIM_bresp}),
                    128'({1'b1, 32'h12, 2'd2}));
        base = pop_count;
        bus.AXIM_bready = 1'b1;
        tick();
        bus.AXIM_bready = 1'b0;
        checkOutput("single_pops", 128'(pop_count - base), 128'(1));
        checkOutput("single_after", 128'({bus.AXIM_bvalid, fill}), 128'({1'b0, 3'd0}));

        // Fill to full, then release one slot.
        $display("[TB] fill to full");
        base = pop_count;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 4'h4, 32'(i), 2'(i), 64'(i * 3), 1'b0);
            tick();
        end
        checkOutput("full_s_ready", 128'(bus.s_ready), 128'(0));
        checkOutput("full_fill", 128'(fill), 128'(4));
        applyStimulus(1'b1, 4'h4, 32'd5, 2'd1, 64'd15, 1'b0);
        tick();
        checkOutput("fifth_held", 128'({bus.s_ready, fill}), 128'({1'b0, 3'd4}));
        bus.AXIM_bready = 1'b1;
        tick();
        bus.AXIM_bready = 1'b0;
        checkOutput("ready_after_pop", 128'({bus.s_ready, fill}), 128'({1'b1, 3'd3}));
        tick();
        bus.s_valid = 1'b0;
        checkOutput("fifth_accepted", 128'({bus.s_ready, fill}), 128'({1'b0, 3'd4}));
        bus.AXIM_bready = 1'b1;
        cyc = 0;
        while (bus.AXIM_bvalid && cyc < 50) begin
            tick();
            cyc++;
        end
        bus.AXIM_bready = 1'b0;
        checkOutput("full_drain_pops", 128'(pop_count - base), 128'(5));
        checkOutput("full_drain_sb", 128'(exp_q.size()), 128'(0));

        // Streaming with both sides always ready.
        $display("[TB] streaming");
        base = pop_count;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 4'h4, 32'(100 + i), 2'(i), 64'(i * 7 + 1), 1'b1);
            tick();
            checkOutput("stream_fill_le1", 128'(fill <= 3'd1), 128'(1));
        end
        bus.s_valid = 1'b0;
        tick();
        checkOutput("stream_rate", 128'(pop_count - base), 128'(100));
        checkOutput("stream_empty", 128'({bus.AXIM_bvalid, fill}), 128'(0));

        // Table of mixed tags.
        $display("[TB] tag table");
        base = pop_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].tag, vecs[i].bid, vecs[i].bresp, vecs[i].buser, 1'b1);
            tick();
            checkOutput($sformatf("tag_drop_%0d", i), 128'(drop), 128'(vecs[i].exp_drop));
            checkOutput($sformatf("tag_count_%0d", i), 128'(drop_count), 128'(vecs[i].exp_count));
        end
        bus.s_valid = 1'b0;
        tick();
        checkOutput("drop_falls", 128'(drop), 128'(0));
        repeat (2) tick();
        checkOutput("tag_good_pops", 128'(pop_count - base), 128'(3));

        // Saturation of the drop counter.
        $display("[TB] drop saturation");
        applyStimulus(1'b1, 4'h3, 32'h0, 2'd0, 64'h0, 1'b0);
        repeat (65530) tick();
        checkOutput("sat_reach", 128'(drop_count), 128'(16'hFFFF));
        repeat (10) tick();
        checkOutput("sat_hold", 128'({drop, drop_count}), 128'({1'b1, 16'hFFFF}));
        bus.s_valid = 1'b0;
        tick();

        // Reset while responses are buffered.
        $display("[TB] reset mid-burst");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h4, 32'(200 + i), 2'd3, 64'(i), 1'b0);
            tick();
        end
        bus.s_valid = 1'b0;
        checkOutput("burst_fill", 128'(fill), 128'(3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_state", 128'({bus.AXIM_bvalid, fill, drop_count, bus.s_ready}), 128'(0));
        tick();
        checkOutput("mid_rst_ready", 128'(bus.s_ready), 128'(1));
        bus.AXIM_bready = 1'b1;
        repeat (3) tick();
        checkOutput("no_stale", 128'({bus.AXIM_bvalid, fill}), 128'(0));

        // Random traffic with backpressure on both sides.
        $display("[TB] random backpressure");
        bad_count = 0;
        sent = 0;
        cyc = 0;
        applyStimulus(1'b0, 4'h4, 32'h0, 2'd0, 64'h0, 1'b0);
        while (sent < 5000 && cyc < 60000) begin
            will_acc = bus.s_valid && bus.s_ready;
            tick();
            cyc++;
            if (will_acc) begin
                sent++;
                if (!cur_good)
                    bad_count++;
            end
            if (sent < 5000) begin
                if (!bus.s_valid || will_acc)
                    applyStimulus($urandom_range(0, 3) != 0,
                                  ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h4,
                                  $urandom, 2'($urandom_range(0, 3)),
                                  {$urandom, $urandom}, $urandom_range(0, 3) != 0);
                else
                    bus.AXIM_bready = ($urandom_range(0, 3) != 0);
            end
        end
        bus.s_valid = 1'b0;
        checkOutput("rand_sent", 128'(sent), 128'(5000));
        bus.AXIM_bready = 1'b1;
        cyc = 0;
        while (bus.AXIM_bvalid && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("rand_drained", 128'({bus.AXIM_bvalid, fill}), 128'(0));
        checkOutput("rand_sb_empty", 128'(exp_q.size()), 128'(0));
        checkOutput("rand_drop_count", 128'(drop_count), 128'(bad_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
